// File: rtl/dcache_fsm.sv
// -----------------------------------------------------------------------------
// dcache_fsm
//   Direct-mapped, write-back, write-allocate data cache sitting between a
//   single-cycle CPU (byte loads/stores) and a word-block data memory.
//   8 lines x 4 bytes; address = {tag[7:5], index[4:2], offset[1:0]}.
//   Hits complete with no stall; misses stall the CPU through busywait while
//   the controller writes back a dirty victim (if any), fetches the new block
//   and installs it. The stalled request then replays as an ordinary hit.
//
// Ports
//   CLK, RESET        clock (rising edge), asynchronous active-low reset
//   read, write       CPU load / store request (both set = store)
//   address           CPU byte address
//   writedata         CPU store byte
//   readdata          CPU load byte
//   busywait          CPU stall
//   mem_read/write    block read / write request toward memory
//   mem_address       block address {tag, index}
//   mem_writedata     victim block, byte0 in [7:0]
//   mem_readdata      fetched block, byte0 in [7:0]
//   mem_busywait      memory busy (raised combinationally with a request)
// -----------------------------------------------------------------------------
module dcache_fsm (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    MEMREAD   = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Line storage. Data and tags carry no reset: valid gates every use.
  logic [31:0] data_q  [8];
  logic [2:0]  tag_q   [8];
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;

  logic [2:0] addr_tag;
  logic [2:0] idx;
  logic [1:0] off;
  logic       req;
  logic       hit;
  logic       wr_hit;   // store merge this cycle
  logic       fill;     // install fetched block this cycle

  assign addr_tag = address[7:5];
  assign idx      = address[4:2];
  assign off      = address[1:0];
  assign req      = read | write;
  assign hit      = valid_q[idx] & (tag_q[idx] == addr_tag);

  // Next-state and outputs. Everything is forced to zero while RESET is low
  // so outputs drop immediately, even mid-transfer.
  always_comb begin
    state_d       = state_q;
    readdata      = 8'h00;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 6'h00;
    mem_writedata = 32'h0;
    wr_hit        = 1'b0;
    fill          = 1'b0;
    if (RESET) begin
      case (state_q)
        IDLE: begin
          readdata = data_q[idx][{off, 3'b000} +: 8];
          if (req) begin
            if (hit) begin
              // read & write together behaves as a store
              wr_hit = write;
            end else begin
              busywait = 1'b1;
              state_d  = dirty_q[idx] ? WRITEBACK : MEMREAD;
            end
          end
        end
        WRITEBACK: begin
          busywait      = 1'b1;
          mem_write     = 1'b1;
          mem_address   = {tag_q[idx], idx};
          mem_writedata = data_q[idx];
          if (!mem_busywait) state_d = MEMREAD;
        end
        MEMREAD: begin
          busywait    = 1'b1;
          mem_read    = 1'b1;
          mem_address = {addr_tag, idx};
          if (!mem_busywait) state_d = UPDATE;
        end
        UPDATE: begin
          busywait = 1'b1;
          fill     = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      data_q[idx] <= mem_readdata;
      tag_q[idx]  <= addr_tag;
    end else if (wr_hit) begin
      data_q[idx][{off, 3'b000} +: 8] <= writedata;
    end
  end

endmodule

// File: tb/tb_dcache_fsm.sv
module tb_dcache_fsm;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        read, write;
  logic [7:0]  address, writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks = 0;
  int errors = 0;

  dcache_fsm dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
    mem_readdata = 32'h0; mem_busywait = 1'b1;

    // reset state, with a request pending
    tick; read = 1'b1; address = 8'h05; #1;
    chk("rst_busywait", busywait, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_readdata", readdata, 0);
    tick; RESET = 1'b1; read = 1'b0; #1;
    chk("idle_noreq_busy", busywait, 0);

    // T1: read miss 0x05, clean fill
    read = 1'b1; address = 8'h05; #1;
    chk("t1_miss_busy", busywait, 1);
    chk("t1_idle_no_mreq", {mem_read, mem_write}, 0);
    tick;
    chk("t1_mr_read", mem_read, 1);
    chk("t1_mr_write", mem_write, 0);
    chk("t1_mr_addr", mem_address, 6'h01);
    chk("t1_mr_busy", busywait, 1);
    mem_readdata = 32'h44332211; mem_busywait = 1'b0;
    tick; mem_busywait = 1'b1; #1;
    chk("t1_upd_mreq", {mem_read, mem_write}, 0);
    chk("t1_upd_busy", busywait, 1);
    tick;
    chk("t1_hit_busy", busywait, 0);
    chk("t1_readdata", readdata, 8'h22);

    // T2: write hit 0xAB -> 0x05
    read = 1'b0; write = 1'b1; writedata = 8'hAB; #1;
    chk("t2_wr_nostall", busywait, 0);
    tick; write = 1'b0; read = 1'b1; #1;
    chk("t2_readback", readdata, 8'hAB);
    chk("t2_rd_nostall", busywait, 0);

    // T3: read 0x25 evicts dirty line 1
    address = 8'h25; #1;
    chk("t3_miss_busy", busywait, 1);
    tick;
    chk("t3_wb_write", mem_write, 1);
    chk("t3_wb_read", mem_read, 0);
    chk("t3_wb_addr", mem_address, 6'h01);
    chk("t3_wb_data", mem_writedata, 32'h4433AB11);
    tick;
    chk("t3_wb_hold", mem_write, 1);
    mem_busywait = 1'b0;
    tick; mem_busywait = 1'b1; #1;
    chk("t3_mr_read", mem_read, 1);
    chk("t3_mr_write", mem_write, 0);
    chk("t3_mr_addr", mem_address, 6'h09);
    mem_readdata = 32'h88776655; mem_busywait = 1'b0;
    tick; mem_busywait = 1'b1;
    tick;
    chk("t3_hit_busy", busywait, 0);
    chk("t3_readdata", readdata, 8'h66);

    // T4: write miss 0x10 on an invalid (clean) line
    read = 1'b0; write = 1'b1; address = 8'h10; writedata = 8'h5A; #1;
    chk("t4_miss_busy", busywait, 1);
    tick;
    chk("t4_mr_read", mem_read, 1);
    chk("t4_no_wb", mem_write, 0);
    chk("t4_mr_addr", mem_address, 6'h04);
    mem_readdata = 32'hDDCCBBAA; mem_busywait = 1'b0;
    tick; mem_busywait = 1'b1;
    tick;
    chk("t4_merge_nostall", busywait, 0);
    tick; write = 1'b0; read = 1'b1; #1;
    chk("t4_byte0", readdata, 8'h5A);
    address = 8'h11; #1;
    chk("t4_byte1", readdata, 8'hBB);

    // T5: long memory latency on read miss 0x4C
    address = 8'h4C; #1;
    chk("t5_miss_busy", busywait, 1);
    tick;
    for (int i = 0; i < 40; i++) begin
      chk("t5_hold", {mem_read, mem_write, busywait}, 3'b101);
      tick;
    end
    mem_readdata = 32'h04030201; mem_busywait = 1'b0;
    tick; mem_busywait = 1'b1; #1;
    chk("t5_upd_busy", busywait, 1);
    tick;
    chk("t5_hit_busy", busywait, 0);
    chk("t5_readdata", readdata, 8'h01);

    // T6: 0x30 evicts dirty line 4, reset dropped during write-back
    address = 8'h30; #1;
    chk("t6_miss_busy", busywait, 1);
    tick;
    chk("t6_wb_write", mem_write, 1);
    chk("t6_wb_addr", mem_address, 6'h04);
    chk("t6_wb_data", mem_writedata, 32'hDDCCBB5A);
    RESET = 1'b0; #1;
    chk("t6_rst_busy", busywait, 0);
    chk("t6_rst_mreq", {mem_read, mem_write}, 0);
    chk("t6_rst_addr", mem_address, 0);
    chk("t6_rst_wdata", mem_writedata, 0);
    chk("t6_rst_rdata", readdata, 0);
    tick; RESET = 1'b1; address = 8'h10; #1;
    chk("t6_remiss_busy", busywait, 1);
    tick;
    chk("t6_clean_mr", {mem_read, mem_write}, 2'b10);
    chk("t6_mr_addr", mem_address, 6'h04);
    mem_readdata = 32'h12345678; mem_busywait = 1'b0;
    tick; mem_busywait = 1'b1;
    tick;
    chk("t6_hit_busy", busywait, 0);
    chk("t6_readdata", readdata, 8'h78);

    // T7: read & write together act as a store
    write = 1'b1; writedata = 8'h77; #1;
    chk("t7_rw_nostall", busywait, 0);
    tick; write = 1'b0; #1;
    chk("t7_readback", readdata, 8'h77);
    read = 1'b0; #1;
    chk("t7_idle_busy", busywait, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
